amci_axi4lite_master: RTL and testbench

- Downstream executor for the AMCI (AXI Master Control Interface).
- Consumes the packed AMCI_MOSI bundle driven by a controller FSM and performs single-beat AXI4-Lite write and read transactions on a memory-mapped bus (GPIO, LED and similar slaves).
- Returns completion status, response codes and read data on the packed AMCI_MISO bundle.
- The write and read channels are independent and may be in flight concurrently.

---
 rtl/amci_axi4lite_master_if.sv | 52 +++++
 rtl/amci_axi4lite_master.sv | 160 ++++++++++++++++
 tb/tb_amci_axi4lite_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amci_axi4lite_master_if.sv
// AXI4-Lite bus bundle between the AMCI executor and the memory-mapped slaves.
// The master modport drives addresses, data and VALIDs; the slave modport the READYs and responses.
interface amci_axi4lite_master_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                  M_AXI_AWPROT;
  logic                        M_AXI_AWVALID;
  logic                        M_AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                        M_AXI_WVALID;
  logic                        M_AXI_WREADY;
  logic [1:0]                  M_AXI_BRESP;
  logic                        M_AXI_BVALID;
  logic                        M_AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                  M_AXI_ARPROT;
  logic                        M_AXI_ARVALID;
  logic                        M_AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                  M_AXI_RRESP;
  logic                        M_AXI_RVALID;
  logic                        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/amci_axi4lite_master.sv
// AMCI executor: turns WRITE/READ strobes into single-beat AXI4-Lite transactions.
// Write and read channels run independent FSMs and may be in flight together.
module amci_axi4lite_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic [2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+1:0] AMCI_MOSI,
  output logic [AXI_DATA_WIDTH+5:0] AMCI_MISO,
  amci_axi4lite_master_if.master m_axi
);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int WR_BIT = 2*AW + DW;
  localparam int RD_BIT = WR_BIT + 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rstate_t;

  logic [AW-1:0] waddr_in;
  logic [DW-1:0] wdata_in;
  logic [AW-1:0] raddr_in;
  logic          write_in;
  logic          read_in;

  assign waddr_in = AMCI_MOSI[AW-1:0];
  assign wdata_in = AMCI_MOSI[AW+DW-1:AW];
  assign raddr_in = AMCI_MOSI[2*AW+DW-1:AW+DW];
  assign write_in = AMCI_MOSI[WR_BIT];
  assign read_in  = AMCI_MOSI[RD_BIT];

  wstate_t       wstate;
  rstate_t       rstate;
  logic [AW-1:0] awaddr;
  logic [DW-1:0] wdata;
  logic          awvalid;
  logic          wvalid;
  logic          bready;
  logic [1:0]    wresp;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  // A channel counts as done once its VALID has dropped or is being accepted now.
  logic aw_done;
  logic w_done;
  assign aw_done = ~awvalid | m_axi.M_AXI_AWREADY;
  assign w_done  = ~wvalid  | m_axi.M_AXI_WREADY;

  // Write FSM: launch AW+W together, wait for both, then collect B.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wstate  <= W_IDLE;
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      wresp   <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (write_in) begin
            awaddr  <= waddr_in;
            wdata   <= wdata_in;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            wstate  <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (awvalid && m_axi.M_AXI_AWREADY) awvalid <= 1'b0;
          if (wvalid && m_axi.M_AXI_WREADY) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            wresp  <= m_axi.M_AXI_BRESP;
            bready <= 1'b0;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: AR handshake, then accept one R beat.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      rstate  <= R_IDLE;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (read_in) begin
            araddr  <= raddr_in;
            arvalid <= 1'b1;
            rstate  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            rdata  <= m_axi.M_AXI_RDATA;
            rresp  <= m_axi.M_AXI_RRESP;
            rready <= 1'b0;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Idle drops in the strobe cycle itself so the controller never sees a stale idle.
  logic widle;
  logic ridle;
  assign widle = (wstate == W_IDLE) & ~write_in;
  assign ridle = (rstate == R_IDLE) & ~read_in;

  assign AMCI_MISO = {rresp, wresp, ridle, widle, rdata};

  assign m_axi.M_AXI_AWADDR  = awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = wdata;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;
  assign m_axi.M_AXI_ARADDR  = araddr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_RREADY  = rready;
endmodule

// File: tb/tb_amci_axi4lite_master.sv
// Bench for amci_axi4lite_master: delay-programmable AXI4-Lite slave,
// expectation queues filled by the stimulus, monitor pops on each handshake.
module tb_amci_axi4lite_master;
  localparam int DW = 32;
  localparam int AW = 32;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] raddr = '0;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic [2*AW+DW+1:0] mosi;
  logic [DW+5:0] miso;

  assign mosi = {rd, wr, raddr, wdata, waddr};

  amci_axi4lite_master_if #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW)
  ) bus ();

  amci_axi4lite_master #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .AMCI_MOSI(mosi),
    .AMCI_MISO(miso),
    .m_axi(bus)
  );

  always #5 CLK = ~CLK;

  wire [DW-1:0] m_rdata = miso[31:0];
  wire          m_widle = miso[32];
  wire          m_ridle = miso[33];
  wire [1:0]    m_wresp = miso[35:34];
  wire [1:0]    m_rresp = miso[37:36];

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour knobs.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_rsp = 2'd0;
  logic [1:0] r_rsp = 2'd0;
  logic [DW-1:0] r_dat = '0;

  // Expectation queues.
  logic [AW-1:0] exp_aw[$];
  logic [DW-1:0] exp_w[$];
  logic [1:0]    exp_b[$];
  logic [AW-1:0] exp_ar[$];
  logic [DW+1:0] exp_r[$];

  bit b_pend = 0;
  bit r_pend = 0;
  int aw_hs = 0;
  int widle_low = 0;

  // Slave model, updated on the falling edge.
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    bus.M_AXI_AWREADY = 0;
    bus.M_AXI_WREADY = 0;
    bus.M_AXI_BVALID = 0;
    bus.M_AXI_BRESP = 0;
    bus.M_AXI_ARREADY = 0;
    bus.M_AXI_RVALID = 0;
    bus.M_AXI_RRESP = 0;
    bus.M_AXI_RDATA = 0;
    forever begin
      @(negedge CLK);
      if (!RESETN) begin
        bus.M_AXI_AWREADY = 0;
        bus.M_AXI_WREADY = 0;
        bus.M_AXI_BVALID = 0;
        bus.M_AXI_ARREADY = 0;
        bus.M_AXI_RVALID = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      end else begin
        if (bus.M_AXI_AWREADY) bus.M_AXI_AWREADY = 0;
        else if (bus.M_AXI_AWVALID) begin
          if (aw_c >= aw_dly) begin bus.M_AXI_AWREADY = 1; aw_c = 0; end
          else aw_c++;
        end
        if (bus.M_AXI_WREADY) bus.M_AXI_WREADY = 0;
        else if (bus.M_AXI_WVALID) begin
          if (w_c >= w_dly) begin bus.M_AXI_WREADY = 1; w_c = 0; end
          else w_c++;
        end
        if (bus.M_AXI_ARREADY) bus.M_AXI_ARREADY = 0;
        else if (bus.M_AXI_ARVALID) begin
          if (ar_c >= ar_dly) begin bus.M_AXI_ARREADY = 1; ar_c = 0; end
          else ar_c++;
        end
        if (bus.M_AXI_BVALID) bus.M_AXI_BVALID = 0;
        else if (bus.M_AXI_BREADY) begin
          if (b_c >= b_dly) begin
            bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = b_rsp; b_c = 0;
          end else b_c++;
        end
        if (bus.M_AXI_RVALID) bus.M_AXI_RVALID = 0;
        else if (bus.M_AXI_RREADY) begin
          if (r_c >= r_dly) begin
            bus.M_AXI_RVALID = 1; bus.M_AXI_RRESP = r_rsp;
            bus.M_AXI_RDATA = r_dat; r_c = 0;
          end else r_c++;
        end
      end
    end
  end

  // Monitor: pops expectations on handshakes and completions.
  initial begin
    bit aw_wait, w_wait, ar_wait;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    forever begin
      @(negedge CLK);
      #2;
      if (!m_widle) widle_low++;
      if (!RESETN) begin
        b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        continue;
      end
      if (b_pend) begin
        b_pend = 0;
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("wresp", m_wresp, exp_b.pop_front());
        if (!wr) chk("widle_after_b", m_widle, 1);
      end
      if (r_pend) begin
        logic [DW+1:0] e;
        r_pend = 0;
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = exp_r.pop_front();
          chk("rdata", m_rdata, e[DW-1:0]);
          chk("rresp", m_rresp, e[DW+1:DW]);
        end
        if (!rd) chk("ridle_after_r", m_ridle, 1);
      end
      if (aw_wait) chk("awvalid_hold", bus.M_AXI_AWVALID, 1);
      if (w_wait) chk("wvalid_hold", bus.M_AXI_WVALID, 1);
      if (ar_wait) chk("arvalid_hold", bus.M_AXI_ARVALID, 1);
      if (bus.M_AXI_BREADY)
        chk("bready_early", bus.M_AXI_AWVALID | bus.M_AXI_WVALID, 0);
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        aw_hs++;
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("awaddr", bus.M_AXI_AWADDR, exp_aw.pop_front());
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else chk("wdata", bus.M_AXI_WDATA, exp_w.pop_front());
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("araddr", bus.M_AXI_ARADDR, exp_ar.pop_front());
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_pend = 1;
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_pend = 1;
      aw_wait = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      w_wait = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      ar_wait = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
    end
  end

  task automatic push_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] r);
    exp_aw.push_back(a);
    exp_w.push_back(d);
    exp_b.push_back(r);
  endtask

  task automatic push_read(logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] r);
    exp_ar.push_back(a);
    exp_r.push_back({r, d});
  endtask

  task automatic pulse_write(logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge CLK);
    waddr = a; wdata = d; wr = 1;
    @(negedge CLK);
    wr = 0;
  endtask

  task automatic pulse_read(logic [AW-1:0] a);
    @(negedge CLK);
    raddr = a; rd = 1;
    @(negedge CLK);
    rd = 0;
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (n < 200 && !(exp_aw.size() == 0 && exp_w.size() == 0 &&
           exp_b.size() == 0 && exp_ar.size() == 0 && exp_r.size() == 0 &&
           !b_pend && !r_pend && m_widle && m_ridle)) begin
      @(negedge CLK);
      #3;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: timeout, got busy expected idle", tag);
    end
  endtask

  initial begin
    int aw0;
    // Reset
    RESETN = 0;
    repeat (3) @(negedge CLK);
    #3;
    chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
    chk("rst_wvalid", bus.M_AXI_WVALID, 0);
    chk("rst_bready", bus.M_AXI_BREADY, 0);
    chk("rst_arvalid", bus.M_AXI_ARVALID, 0);
    chk("rst_rready", bus.M_AXI_RREADY, 0);
    chk("rst_idle", {m_widle, m_ridle}, 2'b11);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_resp", {m_wresp, m_rresp}, 0);
    chk("awprot", bus.M_AXI_AWPROT, 0);
    chk("wstrb", bus.M_AXI_WSTRB, 4'hF);
    @(negedge CLK);
    RESETN = 1;

    // Single write, zero-wait slave
    aw_dly = 0; w_dly = 0; b_dly = 0; b_rsp = 2'd0;
    push_write(32'h4000_0000, 32'h7, 2'd0);
    widle_low = 0;
    pulse_write(32'h4000_0000, 32'h7);
    wait_done("write1");
    chk("widle_low_cycles", widle_low, 3);

    // Single read with wait states
    ar_dly = 4; r_dly = 2; r_dat = 32'h5; r_rsp = 2'd0;
    push_read(32'h4001_0000, 32'h5, 2'd0);
    pulse_read(32'h4001_0000);
    wait_done("read1");

    // Skewed write channels, SLVERR
    aw_dly = 5; w_dly = 0; b_rsp = 2'd2;
    push_write(32'h4000_0010, 32'hA5A5_0001, 2'd2);
    pulse_write(32'h4000_0010, 32'hA5A5_0001);
    @(negedge CLK);
    #3;
    chk("skew_wvalid", bus.M_AXI_WVALID, 0);
    chk("skew_awvalid", bus.M_AXI_AWVALID, 1);
    chk("skew_bready", bus.M_AXI_BREADY, 0);
    wait_done("write_skew");

    // Concurrent write+read, then a busy-time write
    aw_dly = 3; w_dly = 1; b_dly = 1; b_rsp = 2'd1;
    ar_dly = 1; r_dly = 0; r_dat = 32'hDEAD_BEEF; r_rsp = 2'd0;
    aw0 = aw_hs;
    push_write(32'h4002_0004, 32'h1234_5678, 2'd1);
    push_read(32'h4002_0008, 32'hDEAD_BEEF, 2'd0);
    @(negedge CLK);
    waddr = 32'h4002_0004; wdata = 32'h1234_5678; wr = 1;
    raddr = 32'h4002_0008; rd = 1;
    @(negedge CLK);
    wr = 0; rd = 0;
    pulse_write(32'h4002_00F0, 32'hFFFF_0000);
    wait_done("concurrent");
    chk("busy_write_ignored", aw_hs - aw0, 1);

    // Reset during read address phase
    ar_dly = 20;
    pulse_read(32'h4001_0100);
    @(negedge CLK);
    #3;
    chk("pre_rst_arvalid", bus.M_AXI_ARVALID, 1);
    @(negedge CLK);
    RESETN = 0;
    @(negedge CLK);
    #3;
    chk("midrst_arvalid", bus.M_AXI_ARVALID, 0);
    chk("midrst_ridle", m_ridle, 1);
    chk("midrst_rdata", m_rdata, 0);
    @(negedge CLK);
    RESETN = 1;
    ar_dly = 0; r_dly = 0; r_dat = 32'h0000_00C3; r_rsp = 2'd0;
    push_read(32'h4001_0004, 32'h0000_00C3, 2'd0);
    pulse_read(32'h4001_0004);
    wait_done("read_after_rst");

    repeat (3) @(negedge CLK);
    chk("queues_empty", exp_aw.size() + exp_w.size() + exp_b.size() +
        exp_ar.size() + exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
